// File: rtl/drowsiness_ann_core_if.sv
// drowsiness_ann_core_if: bundle of run controls, features, target scores and network results (master drives start/training/in/out_ann_real; slave drives out0/out1/state/delta1/sign1)
interface drowsiness_ann_core_if #(
  parameter int N_IN = 30,
  parameter int N_HID = 5,
  parameter int N_OUT = 3,
  parameter int DW = 10
);
  logic start;
  logic training;
  logic [N_IN-1:0][DW-1:0] in;
  logic [N_OUT-1:0][DW-1:0] out_ann_real;
  logic [N_OUT-1:0][DW-1:0] out1;
  logic [N_HID-1:0][DW-1:0] out0;
  logic [3:0] state;
  logic [N_OUT-1:0][DW-1:0] delta1;
  logic [N_OUT-1:0] sign1;
  modport master (output start, training, in, out_ann_real, input out1, out0, state, delta1, sign1);
  modport slave (input start, training, in, out_ann_real, output out1, out0, state, delta1, sign1);
endinterface

// File: rtl/drowsiness_ann_core.sv
// drowsiness_ann_core: 30-5-3 fixed-point MLP with LFSR weight init and output-layer training (ports: clk, rst_n async active-low, bus slave = start/training/in/out_ann_real in, out0/out1/state/delta1/sign1 out)
module drowsiness_ann_core #(
  parameter int N_IN = 30,
  parameter int N_HID = 5,
  parameter int N_OUT = 3,
  parameter int DW = 10,
  parameter int WW = 8,
  parameter int H_SHIFT = 8,
  parameter int O_SHIFT = 6,
  parameter int LR_SHIFT = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic clk,
  input logic rst_n,
  drowsiness_ann_core_if.slave bus
);
  typedef enum logic [3:0] {IDLE, INIT, HIDDEN, HACT, OUTPUT, OACT, DELTA, UPDATE, DONE} state_t;
  localparam int NH0 = N_HID * N_IN;
  localparam int NW = NH0 + N_OUT * N_HID;
  localparam int DMAX = 2 ** DW - 1;
  localparam int MID = 2 ** (DW - 1);
  localparam int WMAX = 2 ** (WW - 1) - 1;
  state_t st, st_n;
  logic [7:0] cnt;
  logic [15:0] lfsr;
  logic wv;
  logic signed [WW-1:0] w [NW];
  logic [N_IN-1:0][DW-1:0] in_snap;
  logic signed [23:0] acc_h [N_HID];
  logic signed [23:0] acc_o [N_OUT];
  logic [N_HID-1:0][DW-1:0] out0;
  logic [N_OUT-1:0][DW-1:0] out1, delta1;
  logic [N_OUT-1:0] sign1;
  function automatic logic signed [23:0] mul(input logic [DW-1:0] d, input logic signed [WW-1:0] k);
    logic signed [23:0] a, b;
    a = 24'(d);
    b = 24'(k);
    return a * b;
  endfunction
  function automatic logic [DW-1:0] act(input logic signed [23:0] a, input int sh);
    logic signed [23:0] t;
    t = 24'(MID) + (a >>> sh);
    return t < 0 ? '0 : t > DMAX ? DW'(DMAX) : t[DW-1:0];
  endfunction
  function automatic logic signed [WW-1:0] upd(input logic signed [WW-1:0] k, input logic [DW-1:0] d,
                                               input logic [DW-1:0] h, input logic neg);
    logic [2*DW-1:0] p;
    int s, r;
    p = d * h;
    s = int'(p >> LR_SHIFT);
    r = neg ? int'(k) - s : int'(k) + s;
    return r > WMAX ? WW'(WMAX) : r < -WMAX - 1 ? WW'(-WMAX - 1) : WW'(r);
  endfunction
  always_comb begin
    st_n = st;
    case (st)
      IDLE: st_n = bus.start ? (wv ? HIDDEN : INIT) : IDLE;
      INIT: st_n = cnt == 8'(NW - 1) ? HIDDEN : INIT;
      HIDDEN: st_n = cnt == 8'(N_IN - 1) ? HACT : HIDDEN;
      HACT: st_n = OUTPUT;
      OUTPUT: st_n = cnt == 8'(N_HID - 1) ? OACT : OUTPUT;
      OACT: st_n = bus.training ? DELTA : DONE;
      DELTA: st_n = UPDATE;
      UPDATE: st_n = DONE;
      DONE: st_n = bus.start ? HIDDEN : IDLE;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      lfsr <= SEED;
      wv <= 1'b0;
      in_snap <= '0;
      out0 <= '0;
      out1 <= '0;
      delta1 <= '0;
      sign1 <= '0;
      for (int h = 0; h < N_HID; h++) acc_h[h] <= '0;
      for (int k = 0; k < N_OUT; k++) acc_o[k] <= '0;
    end else begin
      st <= st_n;
      cnt <= st_n != st ? '0 : cnt + 8'd1;
      if (st == INIT) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (st == INIT && st_n == HIDDEN) wv <= 1'b1;
      if (st_n == HIDDEN && st != HIDDEN) begin
        in_snap <= bus.in;
        for (int h = 0; h < N_HID; h++) acc_h[h] <= '0;
      end
      if (st == HIDDEN)
        for (int h = 0; h < N_HID; h++) acc_h[h] <= acc_h[h] + mul(in_snap[cnt[4:0]], w[8'(h * N_IN) + cnt]);
      if (st == HACT) begin
        for (int h = 0; h < N_HID; h++) out0[h] <= act(acc_h[h], H_SHIFT);
        for (int k = 0; k < N_OUT; k++) acc_o[k] <= '0;
      end
      if (st == OUTPUT)
        for (int k = 0; k < N_OUT; k++) acc_o[k] <= acc_o[k] + mul(out0[cnt[2:0]], w[8'(NH0 + k * N_HID) + cnt]);
      if (st == OACT)
        for (int k = 0; k < N_OUT; k++) out1[k] <= act(acc_o[k], O_SHIFT);
      if (st == DELTA)
        for (int k = 0; k < N_OUT; k++) begin
          delta1[k] <= bus.out_ann_real[k] >= out1[k] ? bus.out_ann_real[k] - out1[k] : out1[k] - bus.out_ann_real[k];
          sign1[k] <= bus.out_ann_real[k] < out1[k];
        end
    end
  always_ff @(posedge clk) begin
    if (st == INIT) w[cnt] <= {{(WW - 6){lfsr[5]}}, lfsr[5:0]};
    if (st == UPDATE)
      for (int k = 0; k < N_OUT; k++)
        for (int j = 0; j < N_HID; j++)
          w[8'(NH0 + k * N_HID + j)] <= upd(w[8'(NH0 + k * N_HID + j)], delta1[k], out0[j], sign1[k]);
  end
  assign bus.state = st;
  assign bus.out0 = out0;
  assign bus.out1 = out1;
  assign bus.delta1 = delta1;
  assign bus.sign1 = sign1;
endmodule

// File: tb/tb_drowsiness_ann_core.sv
// tb_drowsiness_ann_core: randomized scoreboard bench for drowsiness_ann_core against a loop-level arithmetic model
module tb_drowsiness_ann_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  drowsiness_ann_core_if ifc();
  drowsiness_ann_core dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  typedef struct packed {
    logic [4:0][9:0] o0;
    logic [2:0][9:0] o1;
    logic [2:0][9:0] d1;
    logic [2:0] s1;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int checks = 0, passed = 0;
  int mw0[5][30], mw1[3][5], mo0[5], mo1[3], md[3], ms[3];
  int ix[30], itg[3];
  int dv[30] = '{284, 281, 279, 280, 274, 255, 240, 237, 224, 246, 242, 240, 251, 257, 251,
                 251, 250, 0, 0, 298, 301, 299, 299, 301, 299, 294, 302, 301, 291, 295};
  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask
  function automatic int clamp(input int v, input int lo, input int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
  function automatic void model_reset();
    int l = 'hACE1;
    for (int n = 0; n < 165; n++) begin
      int v = l & 63;
      v = v >= 32 ? v - 64 : v;
      if (n < 150) mw0[n / 30][n % 30] = v;
      else mw1[(n - 150) / 5][(n - 150) % 5] = v;
      l = ((l << 1) | (((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1)) & 'hFFFF;
    end
    for (int h = 0; h < 5; h++) mo0[h] = 0;
    for (int k = 0; k < 3; k++) begin
      mo1[k] = 0;
      md[k] = 0;
      ms[k] = 0;
    end
  endfunction
  task automatic model_pass(input bit tr);
    exp_t e;
    int acc;
    for (int h = 0; h < 5; h++) begin
      acc = 0;
      for (int i = 0; i < 30; i++) acc += ix[i] * mw0[h][i];
      mo0[h] = clamp(512 + (acc >>> 8), 0, 1023);
    end
    for (int k = 0; k < 3; k++) begin
      acc = 0;
      for (int j = 0; j < 5; j++) acc += mo0[j] * mw1[k][j];
      mo1[k] = clamp(512 + (acc >>> 6), 0, 1023);
    end
    if (tr)
      for (int k = 0; k < 3; k++) begin
        md[k] = itg[k] > mo1[k] ? itg[k] - mo1[k] : mo1[k] - itg[k];
        ms[k] = itg[k] < mo1[k] ? 1 : 0;
        for (int j = 0; j < 5; j++) begin
          int s = (md[k] * mo0[j]) >> 16;
          mw1[k][j] = clamp(ms[k] != 0 ? mw1[k][j] - s : mw1[k][j] + s, -128, 127);
        end
      end
    for (int h = 0; h < 5; h++) e.o0[h] = 10'(mo0[h]);
    for (int k = 0; k < 3; k++) begin
      e.o1[k] = 10'(mo1[k]);
      e.d1[k] = 10'(md[k]);
      e.s1[k] = ms[k][0];
    end
    q.push_back(e);
  endtask
  always @(negedge clk)
    if (rst_n && ifc.state == 4'd8) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: DONE reached with no pass pending");
      end else begin
        me = q.pop_front();
        for (int h = 0; h < 5; h++) chk($sformatf("out0[%0d]", h), ifc.out0[h], me.o0[h]);
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("out1[%0d]", k), ifc.out1[k], me.o1[k]);
          chk($sformatf("delta1[%0d]", k), ifc.delta1[k], me.d1[k]);
          chk($sformatf("sign1[%0d]", k), ifc.sign1[k], me.s1[k]);
        end
      end
    end
  task automatic run_pass(input bit tr, input bit first, input bit scramble);
    int ni = 0, pl = 1, n = 0;
    for (int i = 0; i < 30; i++) ifc.in[i] = 10'(ix[i]);
    for (int k = 0; k < 3; k++) ifc.out_ann_real[k] = 10'(itg[k]);
    ifc.training = tr;
    model_pass(tr);
    ifc.start = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (ifc.state == 4'd1) ni++;
    end while (ifc.state != 4'd2 && n < 400);
    ifc.start = 1'b0;
    chk("init_cycles", ni, first ? 165 : 0);
    if (ifc.state != 4'd2) begin
      checks++;
      $display("FAIL hidden_timeout: state %0d, expected 2", ifc.state);
      return;
    end
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (ifc.state == 4'd0) break;
      pl++;
      if (scramble && pl == 6) for (int i = 0; i < 30; i++) ifc.in[i] = 10'($urandom_range(0, 1023));
    end
    chk(tr ? "train_pass_len" : "infer_pass_len", pl, tr ? 40 : 38);
  endtask
  initial begin
    ifc.start = 1'b0;
    ifc.training = 1'b0;
    ifc.in = '0;
    ifc.out_ann_real = '0;
    model_reset();
    #100;
    chk("rst_state", ifc.state, 0);
    chk("rst_out0_zero", ifc.out0 == '0, 1);
    chk("rst_out1_zero", ifc.out1 == '0, 1);
    chk("rst_delta1_zero", ifc.delta1 == '0, 1);
    chk("rst_sign1", ifc.sign1, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_hold", ifc.state, 0);
    for (int i = 0; i < 30; i++) ix[i] = 0;
    itg = '{0, 0, 0};
    run_pass(1'b0, 1'b1, 1'b0);
    for (int h = 0; h < 5; h++) chk($sformatf("zero_in_out0[%0d]", h), ifc.out0[h], 512);
    ix = dv;
    itg = '{2, 999, 2};
    for (int p = 0; p < 200; p++) run_pass(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) ix[i] = 1023;
    itg = '{1023, 0, 1023};
    for (int p = 0; p < 40; p++) run_pass(1'b1, 1'b0, 1'b0);
    ix = dv;
    itg = '{0, 1023, 0};
    for (int p = 0; p < 40; p++) run_pass(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) ix[i] = $urandom_range(0, 1023);
    ix[0] = 123;
    ix[1] = 4;
    ix[2] = 512;
    ix[29] = 44;
    run_pass(1'b0, 1'b0, 1'b0);
    run_pass(1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 30; i++) ix[i] = $urandom_range(0, 1023);
      for (int k = 0; k < 3; k++) itg[k] = $urandom_range(0, 1023);
      run_pass(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end
    ifc.start = 1'b1;
    for (int n = 0; n < 50 && ifc.state != 4'd2; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("mid_hidden_before_reset", ifc.state, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", ifc.state, 0);
    chk("mid_rst_out0_zero", ifc.out0 == '0, 1);
    chk("mid_rst_out1_zero", ifc.out1 == '0, 1);
    chk("mid_rst_delta1_zero", ifc.delta1 == '0, 1);
    chk("mid_rst_sign1", ifc.sign1, 0);
    ifc.start = 1'b0;
    q.delete();
    model_reset();
    #30;
    @(negedge clk) rst_n = 1'b1;
    ix = dv;
    itg = '{2, 999, 2};
    run_pass(1'b1, 1'b1, 1'b0);
    run_pass(1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/drowsiness_ann_core.md
Name: drowsiness_ann_core

Overview:
- 30-input, 5-hidden, 3-output fixed-point feed-forward neural network with on-chip weight initialisation and online output-layer training.
- Sits after the eye/face feature extractor: consumes 30 unsigned 10-bit features and produces 3 class scores.
- When `training` is high, each pass compares the scores against target scores and updates the output-layer weights.

Parameters:
- N_IN, 30, number of input features
- N_HID, 5, hidden neurons
- N_OUT, 3, output neurons
- DW, 10, data width (unsigned)
- WW, 8, weight width (signed two's complement)
- H_SHIFT, 8, hidden accumulator right-shift before activation
- O_SHIFT, 6, output accumulator right-shift before activation
- LR_SHIFT, 16, learning-rate shift
- SEED, 16'hACE1, LFSR seed (must be nonzero)

Ports:
- Clock  in  1  rising-edge clock
- Rst  in  1  asynchronous active-low reset
- Start  in  1  run enable, level-sensitive
- training  in  1  1 = update weights each pass, 0 = inference only
- in  in  30x10  input feature array in[0..29]
- out_ann_real  in  3x10  target scores
- out1  out  3x10  output-layer activations
- out0  out  5x10  hidden-layer activations
- state  out  4  current FSM state
- delta1  out  3x10  |target - out1| per output
- sign1  out  3  1 = target < out1 (negative error)

Behaviour:
- Reset (Rst=0, asynchronous):
  - out0, out1, delta1, sign1 = 0; state = IDLE.
  - weights_valid flag cleared; LFSR = SEED.
- State encoding: IDLE=0, INIT=1, HIDDEN=2, HACT=3, OUTPUT=4, OACT=5, DELTA=6, UPDATE=7, DONE=8.
- IDLE: on Start=1, go to INIT if !weights_valid, else HIDDEN.
- INIT (165 cycles):
  - One weight per cycle: hidden w0[h][i] row-major (150), then output w1[k][h] (15).
  - Each weight = sign-extended LFSR[5:0] (range -32..31).
  - LFSR is 16-bit Fibonacci, taps 16,14,13,11, stepped every INIT cycle.
  - Sets weights_valid, then goes to HIDDEN.
- HIDDEN (30 cycles):
  - The `in` array is snapshotted on entry; mid-pass input changes have no effect.
  - Cycle i: acc_h += in_snap[i]*w0[h][i] for all 5 h in parallel.
  - Accumulators are signed, at least 24 bits, cleared on entry.
- HACT (1 cycle): out0[h] = clamp(512 + (acc_h >>> H_SHIFT), 0, 1023).
- OUTPUT (5 cycles): cycle j: acc_k += out0[j]*w1[k][j] for all 3 k.
- OACT (1 cycle):
  - out1[k] = clamp(512 + (acc_k >>> O_SHIFT), 0, 1023).
  - Next state is DELTA if training=1, else DONE.
- DELTA (1 cycle):
  - out_ann_real is sampled here.
  - delta1[k] = |out_ann_real[k] - out1[k]|; sign1[k] = (out_ann_real[k] < out1[k]).
- UPDATE (1 cycle), all 15 output weights in parallel:
  - step = (delta1[k]*out0[j]) >> LR_SHIFT.
  - w1[k][j] += step if sign1[k]=0, -= step if sign1[k]=1.
  - Result saturates to [-128,127].
  - Hidden weights are never modified after INIT.
- DONE (1 cycle): go to HIDDEN if Start=1, else IDLE.
- Pass length: training pass 40 cycles (HIDDEN..DONE); inference pass 38 cycles.
- Output hold rules:
  - out0 changes only in HACT; out1 only in OACT; delta1/sign1 only in DELTA.
  - All hold their values otherwise, including in IDLE.
- Start deasserted mid-pass: the current pass completes, then DONE → IDLE. Weights are retained; the next Start skips INIT.
- training toggled mid-pass: sampled only at the OACT→next transition.
- Reset mid-operation: immediate return to reset values. The next Start re-runs INIT with the same SEED, so weights are deterministic.
- Arithmetic:
  - Inputs and activations are unsigned; weights are signed.
  - Products are formed signed with a zero-extended data operand.

Test Plan:
- Reset check:
  - Hold Rst=0 for 100 ns → state=0, out0/out1/delta1 all 0, sign1=0.
  - Release with Start=0 → state stays 0.
- Init timing: Rst=1, Start=1 → state=1 for exactly 165 cycles, then 2.
- Zero-input pass: in all 0 → after HACT, out0 = {512,512,512,512,512}. out1 matches a reference model using the LFSR-derived weights.
- Delta/sign: training=1, targets {2,999,2}, in = {284,281,279,280,274,255,240,237,224,246,242,240,251,257,251,251,250,0,0,298,301,299,299,301,299,294,302,301,291,295} → in DELTA:
  - delta1[k] = |target[k] - out1[k]|.
  - sign1[0]=sign1[2]=1 whenever out1>2.
  - sign1[1]=1 only if out1[1]>999.
- Convergence: same stimulus for 750 passes (30000 cycles) → delta1[1] non-increasing across passes once steps are nonzero. No weight wraps; saturation is checked at ±127/-128 by forcing large deltas.
- Inference and mid-run changes:
  - training=0 with a new vector {123,4,512,...,44} → state never enters 6/7; out1 is identical on consecutive passes.
  - Changing `in` mid-HIDDEN does not alter that pass's result.
  - Asserting Rst=0 mid-HIDDEN → outputs zero immediately; the re-run INIT reproduces identical weights.
